// File: rtl/ysyx_24070017_lsu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24070017_lsu_pkg
// Shared constants for the load/store unit:
//   - WORD_LENGTH  : core-wide datapath/address width
//   - OPC_LOAD / OPC_STORE : RV32 major opcodes routed to memory
//   - F3_*         : funct3 access-size/sign encodings
//   - lsu_state_e  : 2-bit FSM state encoding
// ----------------------------------------------------------------------------
package ysyx_24070017_lsu_pkg;

  localparam int WORD_LENGTH = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_24070017_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_24070017_lsu_align
// Purely combinational access formatter for the LSU.
//   i_opcode, i_funct3 : instruction class and access size/sign
//   i_off              : byte offset within the word (address[1:0])
//   i_store_data       : rs2 value for stores
//   i_rdata            : word returned by memory for loads
//   o_is_load/o_is_store/o_is_mem : instruction classification
//   o_fault            : illegal funct3 or misaligned access (memory ops only)
//   o_wmask/o_wdata    : byte strobes and lane-replicated store data
//   o_load_data        : extracted and sign/zero-extended load value
// ----------------------------------------------------------------------------
module ysyx_24070017_lsu_align
  import ysyx_24070017_lsu_pkg::*;
#(
  parameter int WL = WORD_LENGTH,
  parameter int MW = WL / 8
) (
  input  logic [6:0]    i_opcode,
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_off,
  input  logic [WL-1:0] i_store_data,
  input  logic [WL-1:0] i_rdata,
  output logic          o_is_load,
  output logic          o_is_store,
  output logic          o_is_mem,
  output logic          o_fault,
  output logic [MW-1:0] o_wmask,
  output logic [WL-1:0] o_wdata,
  output logic [WL-1:0] o_load_data
);

  logic [WL-1:0] w_shifted;

  assign o_is_load  = (i_opcode == OPC_LOAD);
  assign o_is_store = (i_opcode == OPC_STORE);
  assign o_is_mem   = o_is_load | o_is_store;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_shifted  = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_fault = 1'b0;
    if (o_is_load) begin
      unique case (i_funct3)
        F3_B, F3_BU: o_fault = 1'b0;
        F3_H, F3_HU: o_fault = i_off[0];
        F3_W:        o_fault = (i_off != 2'b00);
        default:     o_fault = 1'b1;
      endcase
    end else if (o_is_store) begin
      unique case (i_funct3)
        F3_B:    o_fault = 1'b0;
        F3_H:    o_fault = i_off[0];
        F3_W:    o_fault = (i_off != 2'b00);
        default: o_fault = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    o_wmask = '0;
    o_wdata = '0;
    if (o_is_store) begin
      unique case (i_funct3)
        F3_B: begin
          o_wmask = MW'(1) << i_off;
          o_wdata = {MW{i_store_data[7:0]}};
        end
        F3_H: begin
          o_wmask = MW'(3) << i_off;
          o_wdata = {(WL/16){i_store_data[15:0]}};
        end
        F3_W: begin
          o_wmask = '1;
          o_wdata = i_store_data;
        end
        default: begin
          o_wmask = '0;
          o_wdata = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_load_data = '0;
    unique case (i_funct3)
      F3_B:    o_load_data = {{(WL-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    o_load_data = {{(WL-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_data = w_shifted;
      F3_BU:   o_load_data = {{(WL-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   o_load_data = {{(WL-16){1'b0}}, w_shifted[15:0]};
      default: o_load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24070017_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_24070017_lsu
// Load/store unit behind the ALU. Accepts one instruction at a time, runs a
// valid/ready memory request for legal aligned loads/stores, and delivers one
// write-back value per instruction.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready               : instruction handshake from execute
//   in_opcode/in_funct3             : instruction class and access size
//   in_alu_result                   : effective address or pass-through value
//   in_store_data                   : rs2 for stores
//   mem_req_valid/mem_req_ready     : memory request handshake
//   mem_addr/mem_wen/mem_wdata/mem_wmask : request fields (word aligned)
//   mem_resp_valid/mem_rdata        : memory response
//   out_valid/out_ready             : write-back handshake
//   out_data/out_fault              : write-back value and fault flag
// ----------------------------------------------------------------------------
module ysyx_24070017_lsu
  import ysyx_24070017_lsu_pkg::*;
#(
  parameter int WORD_LENGTH = ysyx_24070017_lsu_pkg::WORD_LENGTH,
  parameter int MASK_WIDTH  = WORD_LENGTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [WORD_LENGTH-1:0] in_alu_result,
  input  logic [WORD_LENGTH-1:0] in_store_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_wen,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0]  mem_wmask,
  input  logic                   mem_resp_valid,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_fault
);

  lsu_state_e             r_state;
  logic                   r_in_ready;
  logic [6:0]             r_opcode;
  logic [2:0]             r_funct3;
  logic [1:0]             r_off;
  logic                   r_mem_req_valid;
  logic [WORD_LENGTH-1:0] r_mem_addr;
  logic                   r_mem_wen;
  logic [WORD_LENGTH-1:0] r_mem_wdata;
  logic [MASK_WIDTH-1:0]  r_mem_wmask;
  logic                   r_out_valid;
  logic [WORD_LENGTH-1:0] r_out_data;
  logic                   r_out_fault;

  logic [6:0]             w_opcode;
  logic [2:0]             w_funct3;
  logic [1:0]             w_off;
  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_is_mem;
  logic                   w_fault;
  logic [MASK_WIDTH-1:0]  w_wmask;
  logic [WORD_LENGTH-1:0] w_wdata;
  logic [WORD_LENGTH-1:0] w_load_data;

  // The single formatter serves both phases: in IDLE it classifies the live
  // inputs, afterwards it works on the latched instruction for load extraction.
  assign w_opcode = (r_state == ST_IDLE) ? in_opcode         : r_opcode;
  assign w_funct3 = (r_state == ST_IDLE) ? in_funct3         : r_funct3;
  assign w_off    = (r_state == ST_IDLE) ? in_alu_result[1:0] : r_off;

  ysyx_24070017_lsu_align #(
    .WL (WORD_LENGTH),
    .MW (MASK_WIDTH)
  ) u_align (
    .i_opcode     (w_opcode),
    .i_funct3     (w_funct3),
    .i_off        (w_off),
    .i_store_data (in_store_data),
    .i_rdata      (mem_rdata),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_is_mem     (w_is_mem),
    .o_fault      (w_fault),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_in_ready      <= 1'b1;
      r_opcode        <= '0;
      r_funct3        <= '0;
      r_off           <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_fault     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_opcode   <= in_opcode;
            r_funct3   <= in_funct3;
            r_off      <= in_alu_result[1:0];
            r_in_ready <= 1'b0;
            if (w_is_mem && !w_fault) begin
              r_state         <= ST_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {in_alu_result[WORD_LENGTH-1:2], 2'b00};
              r_mem_wen       <= w_is_store;
              r_mem_wdata     <= w_wdata;
              r_mem_wmask     <= w_wmask;
            end else begin
              // Faults and pass-through complete without touching memory.
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_out_fault <= w_fault;
              r_out_data  <= w_is_mem ? '0 : in_alu_result;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_state         <= ST_WAIT;
            r_mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_fault <= 1'b0;
            r_out_data  <= w_is_load ? w_load_data : '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_fault     = r_out_fault;

endmodule

// File: doc/ysyx_24070017_lsu.md
Name: ysyx_24070017_lsu

Overview:
Load/store unit directly downstream of the ALU in the NPC core. It consumes the ALU result either as an effective address for loads/stores or as a plain result for all other instructions. It runs a valid/ready memory transaction and hands one write-back value per instruction to the register-file write stage. It turns the single-cycle core's memory access into a multi-cycle, handshaked operation.

Parameters:
WORD_LENGTH, 32, datapath and address width (matches ysyx_24070017_WORD_LENGTH)
MASK_WIDTH, WORD_LENGTH/8, byte-strobe width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  LSU can accept
in_opcode  in  7  instruction opcode (0000011 LOAD, 0100011 STORE, other = pass-through)
in_funct3  in  3  access size/sign
in_alu_result  in  WORD_LENGTH  effective address or pass-through result
in_store_data  in  WORD_LENGTH  rs2 value for stores
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  WORD_LENGTH  word-aligned address (low 2 bits zero)
mem_wen  out  1  1 = write
mem_wdata  out  WORD_LENGTH  lane-shifted store data
mem_wmask  out  MASK_WIDTH  byte strobes
mem_resp_valid  in  1  read data / write ack valid
mem_rdata  in  WORD_LENGTH  read word
out_valid  out  1  write-back value valid
out_ready  in  1  write-back consumer ready
out_data  out  WORD_LENGTH  extended load data, or pass-through result (0 for stores)
out_fault  out  1  misaligned address or illegal funct3; no memory access performed

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; mem_req_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0; out_valid=0, out_data=0, out_fault=0. Asserting reset mid-transaction drops it silently. The memory side must tolerate the abandoned request.
- FSM states: IDLE, REQ, WAIT, DONE. One instruction in flight. No pipelining.
- IDLE: in_ready=1. When in_valid&in_ready, latch all inputs.
  - LOAD/STORE, legal and aligned: go to REQ.
  - Fault: go to DONE with out_fault=1, out_data=0.
  - Pass-through: go to DONE with out_data=in_alu_result.
- REQ: mem_req_valid=1. Address, wen, wdata and wmask are held stable until mem_req_ready. On mem_req_ready go to WAIT. mem_resp_valid is ignored in REQ.
- WAIT: on mem_resp_valid, go to DONE.
  - Load: format mem_rdata into out_data.
  - Store: out_data=0.
- DONE: out_valid=1; out_data and out_fault held stable. On out_ready return to IDLE. in_ready is 0 in REQ, WAIT and DONE.
- Minimum latency, memory op: accept at cycle 0, REQ at cycle 1, response no earlier than cycle 2, out_valid at cycle 3.
- Minimum latency, pass-through or fault: out_valid at cycle 1.
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - Anything else is a fault.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00. Otherwise fault.
- Store lanes: off = addr[1:0].
  - SB: wmask = 0001<<off; wdata = byte replicated to all 4 lanes.
  - SH: wmask = 0011<<off; wdata = half replicated to both halves.
  - SW: wmask = 1111; wdata = data.
- Load extraction: select the byte/half at off from mem_rdata. B/H are sign-extended; BU/HU are zero-extended to WORD_LENGTH.
- For loads, mem_wen=0 and mem_wmask=0.

Decomposition:
- Shared package/header holds:
  - opcode constants OPC_LOAD and OPC_STORE;
  - funct3 size constants;
  - FSM state encoding (2 bits);
  - WORD_LENGTH, reused from the existing core-wide define.
- Natural sub-module: ysyx_24070017_lsu_align. Combinational; contains store lane/mask generation, load extract/extend, and the fault check. Instantiated once.
- The FSM and latches stay in the top block.

Test Plan:
- LW, addr 0x80000004, mem_rdata 0xDEADBEEF, req_ready and resp each after 1 cycle -> mem_addr 0x80000004, wen 0; out_data 0xDEADBEEF, out_fault 0, out_valid at cycle 3.
- LB addr 0x80000003 with mem_rdata 0x80FF0011 -> out_data 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x80000002 -> 0x000080FF.
- SB addr 0x80000001, store_data 0x000000AB -> wmask 0010, wdata 0xABABABAB, wen 1. SH addr 0x80000002, data 0x1234 -> wmask 1100, wdata 0x12341234. After ack, out_data 0.
- SW addr 0x80000002, and LH addr 0x80000001 -> no mem_req_valid ever; out_valid cycle 1 with out_fault 1. Load funct3 011 -> same fault response.
- Back-pressure: mem_req_ready low 5 cycles, then out_ready low 3 cycles -> request fields and out_data stable throughout; in_ready 0 until out handshake.
- Pass-through opcode 0110011, alu_result 0x55 -> out_data 0x55 at cycle 1. rst_n low while in WAIT -> all outputs at reset values immediately; in_ready 1 after release.
